// File: rtl/piso_frame_serializer.sv
// piso_frame_serializer: parallel-in, serial-out frame transmitter.
// Accepts a WIDTH-bit word over valid/ready, shifts it out MSB first on BitOut
// with a one-cycle BitValid strobe at the start of each SHIFT_DIV-cycle bit period.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit period.
module piso_frame_serializer #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned SHIFT_DIV = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] LoadData,
  input  logic             LoadValid,
  output logic             LoadReady,
  input  logic             Abort,
  output logic             BitOut,
  output logic             BitValid,
  output logic             Busy,
  output logic             FrameDone
);

`ifdef PISO_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam int unsigned DW = $clog2(SHIFT_DIV + 1);

  localparam logic [BW-1:0] NBITS_L  = BW'(NBITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic [DW-1:0]    div_q, div_d;
  logic             bo_q, bo_d;
  logic             bv_q, bv_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] frame_word;

  // Full bit sequence of one frame, MSB transmitted first.
`ifdef PISO_PARITY_EN
  assign frame_word = {LoadData, ^LoadData};
`else
  assign frame_word = LoadData;
`endif

  assign LoadReady = (state_q == IDLE);
  assign Busy      = (state_q == SHIFT);
  assign BitOut    = bo_q;
  assign BitValid  = bv_q;
  assign FrameDone = done_q;

  // Next-state logic: the first bit is placed on BitOut at the accepting edge,
  // so the shift register only holds the bits still to be sent.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bits_d  = bits_q;
    div_d   = div_q;
    bo_d    = bo_q;
    bv_d    = 1'b0;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      bo_d = 1'b0;
      if (LoadValid && !Abort) begin
        state_d = SHIFT;
        sh_d    = frame_word << 1;
        bits_d  = NBITS_L;
        div_d   = '0;
        bo_d    = frame_word[NBITS-1];
        bv_d    = 1'b1;
      end
    end else begin
      if (Abort) begin
        state_d = IDLE;
        sh_d    = '0;
        bits_d  = '0;
        div_d   = '0;
        bo_d    = 1'b0;
      end else if (div_q == DIV_LAST) begin
        if (bits_q == BW'(1)) begin
          state_d = IDLE;
          sh_d    = '0;
          bits_d  = '0;
          div_d   = '0;
          bo_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          bits_d = bits_q - BW'(1);
          bo_d   = sh_q[NBITS-1];
          sh_d   = sh_q << 1;
          div_d  = '0;
          bv_d   = 1'b1;
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  // State and output registers, cleared asynchronously by active-low Rst.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bits_q  <= '0;
      div_q   <= '0;
      bo_q    <= 1'b0;
      bv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bits_q  <= bits_d;
      div_q   <= div_d;
      bo_q    <= bo_d;
      bv_q    <= bv_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed self-checking bench for piso_frame_serializer (SHIFT_DIV=1 and 3).
module tb_piso_frame_serializer;

  localparam int unsigned W = 6;
`ifdef PISO_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  logic [W-1:0] d1, d3;
  logic v1, v3, a1, a3;
  logic rdy1, bo1, bv1, busy1, done1;
  logic rdy3, bo3, bv3, busy3, done3;

  int checks   = 0;
  int failures = 0;
  logic [NB-1:0] sr;

  always #5 Clk = ~Clk;

  piso_frame_serializer #(.WIDTH(W), .SHIFT_DIV(1)) u1 (
    .Clk(Clk), .Rst(Rst), .LoadData(d1), .LoadValid(v1), .LoadReady(rdy1),
    .Abort(a1), .BitOut(bo1), .BitValid(bv1), .Busy(busy1), .FrameDone(done1)
  );

  piso_frame_serializer #(.WIDTH(W), .SHIFT_DIV(3)) u3 (
    .Clk(Clk), .Rst(Rst), .LoadData(d3), .LoadValid(v3), .LoadReady(rdy3),
    .Abort(a3), .BitOut(bo3), .BitValid(bv3), .Busy(busy3), .FrameDone(done3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected i-th transmitted bit of a frame carrying word w.
  function automatic logic expbit(input logic [W-1:0] w, input int unsigned i);
    if (i < W) return w[W-1-i];
    return ^w;
  endfunction

  function automatic logic [NB-1:0] expframe(input logic [W-1:0] w);
    logic [NB-1:0] f;
    for (int unsigned i = 0; i < NB; i++) f[NB-1-i] = expbit(w, i);
    return f;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    d1 = '0; d3 = '0; v1 = 0; v3 = 0; a1 = 0; a3 = 0;
    #2;
    chk("rst_bitout", {31'd0, bo1}, 0);
    chk("rst_bitvalid", {31'd0, bv1}, 0);
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_done", {31'd0, done1}, 0);
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ready", {31'd0, rdy1}, 1);
      chk("idle_busy", {31'd0, busy1}, 0);
      chk("idle_bitout", {31'd0, bo1}, 0);
      chk("idle_bitvalid", {31'd0, bv1}, 0);
    end

    // Single frame, SHIFT_DIV=1
    d1 = 6'b101100; v1 = 1;
    step();
    v1 = 0; d1 = '0;
    sr = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      chk("single_bit", {31'd0, bo1}, {31'd0, expbit(6'b101100, i)});
      chk("single_valid", {31'd0, bv1}, 1);
      chk("single_busy", {31'd0, busy1}, 1);
      chk("single_done_early", {31'd0, done1}, 0);
      if (bv1) sr = {sr[NB-2:0], bo1};
      step();
    end
    chk("single_done", {31'd0, done1}, 1);
    chk("single_end_bitout", {31'd0, bo1}, 0);
    chk("single_end_ready", {31'd0, rdy1}, 1);
    chk("single_sipo", 32'(sr), 32'(expframe(6'b101100)));
    step();
    chk("single_done_pulse", {31'd0, done1}, 0);

    // Divided rate, SHIFT_DIV=3
    d3 = 6'b010011; v3 = 1;
    step();
    v3 = 0;
    for (int unsigned c = 0; c < NB * 3; c++) begin
      chk("div_valid", {31'd0, bv3}, {31'd0, (c % 3) == 0});
      chk("div_bit", {31'd0, bo3}, {31'd0, expbit(6'b010011, c / 3)});
      chk("div_busy", {31'd0, busy3}, 1);
      chk("div_done_early", {31'd0, done3}, 0);
      step();
    end
    chk("div_done", {31'd0, done3}, 1);
    chk("div_busy_end", {31'd0, busy3}, 0);

    // Back-to-back with LoadValid held
    d1 = 6'h2A; v1 = 1;
    step();
    d1 = 6'h15;
    for (int unsigned i = 0; i < NB; i++) begin
      chk("b2b_bit_a", {31'd0, bo1}, {31'd0, expbit(6'h2A, i)});
      chk("b2b_valid_a", {31'd0, bv1}, 1);
      step();
    end
    chk("b2b_done_a", {31'd0, done1}, 1);
    chk("b2b_ready_a", {31'd0, rdy1}, 1);
    step();
    v1 = 0;
    for (int unsigned i = 0; i < NB; i++) begin
      chk("b2b_bit_b", {31'd0, bo1}, {31'd0, expbit(6'h15, i)});
      chk("b2b_valid_b", {31'd0, bv1}, 1);
      step();
    end
    chk("b2b_done_b", {31'd0, done1}, 1);
    step();

    // Abort after 3rd bit
    d1 = 6'h3F; v1 = 1;
    step();
    v1 = 0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_pre_bit", {31'd0, bo1}, 1);
      step();
    end
    a1 = 1;
    step();
    a1 = 0;
    chk("abort_bitout", {31'd0, bo1}, 0);
    chk("abort_bitvalid", {31'd0, bv1}, 0);
    chk("abort_busy", {31'd0, busy1}, 0);
    chk("abort_ready", {31'd0, rdy1}, 1);
    for (int i = 0; i < NB; i++) begin
      chk("abort_no_done", {31'd0, done1}, 0);
      step();
    end

    // Abort beats LoadValid in IDLE
    d1 = 6'h3F; v1 = 1; a1 = 1;
    step();
    v1 = 0; a1 = 0;
    chk("abort_idle_busy", {31'd0, busy1}, 0);
    chk("abort_idle_bv", {31'd0, bv1}, 0);

    // Abort on the final edge suppresses FrameDone
    d1 = 6'h3F; v1 = 1;
    step();
    v1 = 0;
    for (int unsigned i = 0; i < NB - 1; i++) step();
    chk("abort_last_busy", {31'd0, busy1}, 1);
    a1 = 1;
    step();
    a1 = 0;
    chk("abort_last_done", {31'd0, done1}, 0);
    chk("abort_last_busy_end", {31'd0, busy1}, 0);

    // Reset mid-frame clears outputs asynchronously
    d1 = 6'h3F; v1 = 1;
    step();
    v1 = 0;
    step();
    chk("rstmid_busy_pre", {31'd0, busy1}, 1);
    #2;
    Rst = 0;
    #1;
    chk("rstmid_bitout", {31'd0, bo1}, 0);
    chk("rstmid_bitvalid", {31'd0, bv1}, 0);
    chk("rstmid_busy", {31'd0, busy1}, 0);
    #2;
    Rst = 1;
    for (int i = 0; i < NB + 1; i++) begin
      step();
      chk("rstmid_no_done", {31'd0, done1}, 0);
    end

`ifdef PISO_PARITY_EN
    // Parity bit values
    d1 = 6'b110100; v1 = 1;
    step();
    v1 = 0;
    for (int unsigned i = 0; i < NB - 1; i++) step();
    chk("par_bit1", {31'd0, bo1}, 1);
    chk("par_valid1", {31'd0, bv1}, 1);
    step();
    chk("par_done1", {31'd0, done1}, 1);
    d1 = 6'b110000; v1 = 1;
    step();
    v1 = 0;
    for (int unsigned i = 0; i < NB - 1; i++) step();
    chk("par_bit0", {31'd0, bo1}, 0);
    chk("par_valid0", {31'd0, bv1}, 1);
    step();
    chk("par_done0", {31'd0, done1}, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_frame_serializer.md
Name: piso_frame_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first on BitOut.
- Issues a one-cycle BitValid strobe per bit, so BitOut/BitValid drive a serial-in register's BitIn/Shift pins directly.
- Sits between the game logic that produces segment patterns and the serial-in display/pattern registers.

Parameters:
- WIDTH, 6, word length in bits (>=2).
- SHIFT_DIV, 1, clock cycles each bit is held (>=1). The internal divider counter is $clog2(SHIFT_DIV+1) bits wide.

Ports:
- Clk  input  1  system clock, all state on posedge.
- Rst  input  1  asynchronous, active-low reset.
- LoadData  input  WIDTH  word to transmit; sampled on accepted load.
- LoadValid  input  1  producer offers LoadData.
- LoadReady  output  1  serializer can accept a word.
- Abort  input  1  synchronous frame cancel.
- BitOut  output  1  current serial bit (registered).
- BitValid  output  1  one-cycle strobe marking the first cycle of each bit period.
- Busy  output  1  frame in progress.
- FrameDone  output  1  one-cycle pulse after the last bit period completes normally.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; shift reg=0, bit counter=0, divider=0; BitOut=0, BitValid=0, Busy=0, FrameDone=0. LoadReady=1 once Rst=1.
- States: IDLE, SHIFT. LoadReady=(state==IDLE); Busy=(state==SHIFT).
- IDLE:
  - BitOut=0, BitValid=0.
  - Accept when LoadValid&LoadReady&!Abort at edge E0: capture LoadData, bits_left=NBITS, divider=0, go SHIFT.
- SHIFT, cycle after E0: BitOut=LoadData[WIDTH-1], BitValid=1.
- Bit period:
  - Each bit is held exactly SHIFT_DIV cycles. BitValid=1 only in the first cycle of each period.
  - At the end of a period, shift reg moves left by one, next bit appears on BitOut, and BitValid pulses again.
  - Bit order: D[WIDTH-1] ... D[0].
- NBITS=WIDTH (plus 1 with parity, see below). SHIFT lasts exactly NBITS*SHIFT_DIV cycles.
- Frame end:
  - At the edge ending the last period: go IDLE, FrameDone=1 for one cycle, BitOut=0, BitValid=0.
  - LoadReady=1 in that same cycle, so back-to-back frames are accepted. Frame pitch is NBITS*SHIFT_DIV+1 cycles.
- LoadValid while not in IDLE is ignored (LoadReady=0). LoadData is not held internally beyond capture; the producer may change it after acceptance.
- Abort:
  - In SHIFT: at the next edge go IDLE; BitOut=0, BitValid=0, no FrameDone; remaining bits discarded.
  - In IDLE: Abort wins over LoadValid, no capture.
  - On the final edge of a frame: Abort wins, no FrameDone.
- Rst asserted mid-frame: outputs clear immediately (asynchronous), and no FrameDone is produced.
- SHIFT_DIV=1: BitValid stays high for every cycle of SHIFT.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - NBITS=WIDTH+1.
  - After D[0], one extra bit period carries even parity (XOR of the captured word) with its own BitValid strobe.
  - FrameDone follows the parity period.
- Undefined: NBITS=WIDTH, no parity logic synthesized.

Test Plan:
- Reset and idle: Rst=0 then 1 with no load -> LoadReady=1, Busy=0, BitOut=0, BitValid=0 every cycle.
- Single frame: SHIFT_DIV=1, load 6'b101100 -> over the next 6 cycles BitOut=1,0,1,1,0,0 with BitValid=1 each cycle; FrameDone=1 on cycle 7. A serial-in register fed by BitOut/BitValid reads 101100.
- Divided rate: SHIFT_DIV=3, load 6'b010011 -> each bit held 3 cycles, BitValid high in cycles 1,4,7,10,13,16 only; Busy high for 18 cycles; FrameDone on cycle 19.
- Back-to-back: hold LoadValid=1 with 6'h2A then 6'h15 -> second word accepted in the FrameDone cycle; bitstream 101010 then 010101 with no gap cycle beyond the FrameDone cycle.
- Abort/reset mid-frame:
  - Abort after 3rd bit of 6'h3F -> IDLE next cycle, BitOut=0, no FrameDone, LoadReady=1.
  - Rst pulse mid-frame -> all outputs 0 immediately.
- Parity (PISO_PARITY_EN): load 6'b110100 -> 7 strobes, 7th bit=1. Load 6'b110000 -> 7th bit=0. FrameDone follows the 7th period.
